// File: rtl/alu32_behavioral.sv
// alu32_behavioral: 32-bit 16-op ALU with a registered result and carry.
// Define ALU32_FLAGS_EN to add the registered zero/neg/ovf flag outputs.
module alu32_behavioral #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] f,
   output logic             cout,
`ifdef ALU32_FLAGS_EN
   output logic             zero,
   output logic             neg,
   output logic             ovf,
`endif
   output logic             out_valid
);

   logic             arith;
   logic             ci;
   logic [WIDTH-1:0] y;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             co;
   logic             ov;

   assign arith = (sel[3:2] == 2'b00);
   // Gate cin so an X on it cannot leak into logic or shift results.
   assign ci    = arith ? cin : 1'b0;

   always_comb begin
      y = '0;
      unique case (sel[1:0])
         2'b00: y = '0;
         2'b01: y = b;
         2'b10: y = ~b;
         2'b11: y = '1;
         default: y = '0;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

   always_comb begin
      res = '0;
      co  = 1'b0;
      ov  = 1'b0;
      unique case (1'b1)
         sel[3]: begin
            if (sel[2]) begin
               res = {a[WIDTH-2:0], 1'b0};
               co  = a[WIDTH-1];
            end else begin
               res = {1'b0, a[WIDTH-1:1]};
               co  = a[0];
            end
         end
         (!sel[3] && sel[2]): begin
            unique case (sel[1:0])
               2'b00: res = a & b;
               2'b01: res = a | b;
               2'b10: res = a ^ b;
               2'b11: res = ~a;
               default: res = '0;
            endcase
         end
         arith: begin
            res = sum[WIDTH-1:0];
            co  = sum[WIDTH];
            ov  = (a[WIDTH-1] == y[WIDTH-1]) &&
                  (res[WIDTH-1] != a[WIDTH-1]);
         end
         default: begin
            res = '0;
            co  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            f    <= res;
            cout <= co;
         end
      end
   end

`ifdef ALU32_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
         neg  <= 1'b0;
         ovf  <= 1'b0;
      end else if (in_valid) begin
         zero <= (res == '0);
         neg  <= res[WIDTH-1];
         ovf  <= ov;
      end
   end
`else
   logic unused_ov;
   assign unused_ov = ov;
`endif

endmodule

// File: tb/tb_alu32_behavioral.sv
// tb_alu32_behavioral: directed vectors plus randomized traffic
// checked against an arithmetic reference model.
module tb_alu32_behavioral;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic [3:0]  sel;
   logic [31:0] f;
   logic        cout;
   logic        out_valid;
`ifdef ALU32_FLAGS_EN
   logic        zero;
   logic        neg;
   logic        ovf;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_f;
   logic        exp_c;
   logic        exp_v;
   logic        exp_z;
   logic        exp_n;
   logic        exp_o;

   alu32_behavioral #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sel       (sel),
      .f         (f),
      .cout      (cout),
`ifdef ALU32_FLAGS_EN
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
`endif
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ysel(input logic [31:0] bb,
                                        input logic [1:0] s);
      case (s)
         2'd0: return 32'd0;
         2'd1: return bb;
         2'd2: return ~bb;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Reference: returns {ovf, cout, f} from plain integer arithmetic.
   function automatic logic [33:0] model(input logic [31:0] aa,
                                         input logic [31:0] bb,
                                         input logic [3:0] s,
                                         input logic c);
      logic [31:0] yy;
      longint unsigned u;
      longint sg;
      if (s[3]) begin
         if (s[2]) return {1'b0, aa[31], aa << 1};
         return {1'b0, aa[0], aa >> 1};
      end
      if (s[2]) begin
         case (s[1:0])
            2'd0: return {2'b00, aa & bb};
            2'd1: return {2'b00, aa | bb};
            2'd2: return {2'b00, aa ^ bb};
            default: return {2'b00, ~aa};
         endcase
      end
      yy = ysel(bb, s[1:0]);
      u  = longint'(aa) + longint'(yy) + longint'(c);
      sg = longint'($signed(aa)) + longint'($signed(yy)) + longint'(c);
      return {(sg > 64'sd2147483647) || (sg < -64'sd2147483648),
              u[32], u[31:0]};
   endfunction

   task automatic expect_op(input logic [31:0] aa, input logic [31:0] bb,
                            input logic [3:0] s, input logic c);
      logic [33:0] r;
      r     = model(aa, bb, s, c);
      exp_f = r[31:0];
      exp_c = r[32];
      exp_o = r[33];
      exp_z = (r[31:0] == 32'd0);
      exp_n = r[31];
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".f"}, 64'(f), 64'(exp_f));
      chk({tag, ".cout"}, 64'(cout), 64'(exp_c));
      chk({tag, ".vld"}, 64'(out_valid), 64'(exp_v));
`ifdef ALU32_FLAGS_EN
      chk({tag, ".zero"}, 64'(zero), 64'(exp_z));
      chk({tag, ".neg"}, 64'(neg), 64'(exp_n));
      chk({tag, ".ovf"}, 64'(ovf), 64'(exp_o));
`endif
   endtask

   // One operation; result compared against spec-given constants.
   task automatic dir(input string tag, input logic [31:0] aa,
                      input logic [31:0] bb, input logic [3:0] s,
                      input logic c, input logic [31:0] ef,
                      input logic ec);
      @(negedge clk);
      a = aa; b = bb; sel = s; cin = c; in_valid = 1'b1;
      expect_op(aa, bb, s, c);
      exp_v = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cin = 1'b0;
      chk({tag, ".f"}, 64'(f), 64'(ef));
      chk({tag, ".cout"}, 64'(cout), 64'(ec));
      check_out({tag, ".m"});
      exp_v = 1'b0;
   endtask

   localparam logic [31:0] TA = 32'hA5A5_F0F0;
   localparam logic [31:0] TB = 32'h0F0F_5A5A;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0; sel = '0;
      exp_f = '0; exp_c = 1'b0; exp_v = 1'b0;
      exp_z = 1'b0; exp_n = 1'b0; exp_o = 1'b0;
      repeat (2) @(negedge clk);
      check_out("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_out("idle");

      dir("add0c0", TA, TB, 4'b0000, 1'b0, 32'hA5A5_F0F0, 1'b0);
      dir("add0c1", TA, TB, 4'b0000, 1'b1, 32'hA5A5_F0F1, 1'b0);
      dir("dec_c0", TA, TB, 4'b0011, 1'b0, 32'hA5A5_F0EF, 1'b1);
      dir("dec_c1", TA, TB, 4'b0011, 1'b1, 32'hA5A5_F0F0, 1'b1);
      dir("add", TA, TB, 4'b0001, 1'b0, 32'hB4B5_4B4A, 1'b0);
      dir("sub", TA, TB, 4'b0010, 1'b1, 32'h9696_9696, 1'b1);
      dir("wrap", 32'hFFFF_FFFF, 32'd1, 4'b0001, 1'b0, 32'd0, 1'b1);
      dir("and", TA, TB, 4'b0100, 1'bx, 32'h0505_5050, 1'b0);
      dir("or", TA, TB, 4'b0101, 1'bx, 32'hAFAF_FAFA, 1'b0);
      dir("xor", TA, TB, 4'b0110, 1'bx, 32'hAAAA_AAAA, 1'b0);
      dir("not", TA, TB, 4'b0111, 1'bx, 32'h5A5A_0F0F, 1'b0);
      dir("shr", TA, TB, 4'b1000, 1'bx, 32'h52D2_F878, 1'b0);
      dir("shl", TA, TB, 4'b1100, 1'bx, 32'h4B4B_E1E0, 1'b1);
      @(negedge clk);
      chk("hold.f", 64'(f), 64'h4B4B_E1E0);
      chk("hold.vld", 64'(out_valid), 64'd0);
      dir("ovf", 32'h7FFF_FFFF, 32'd1, 4'b0001, 1'b0, 32'h8000_0000, 1'b0);
`ifdef ALU32_FLAGS_EN
      chk("ovf.flag", 64'(ovf), 64'd1);
      chk("neg.flag", 64'(neg), 64'd1);
`endif
      dir("xsame", TB, TB, 4'b0110, 1'b0, 32'd0, 1'b0);
`ifdef ALU32_FLAGS_EN
      chk("zero.flag", 64'(zero), 64'd1);
`endif

      // Randomized traffic with gaps; back-to-back when in_valid stays high.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i > 0) check_out("rnd");
         in_valid = ($urandom_range(0, 4) != 0);
         a   = $urandom;
         b   = $urandom;
         sel = 4'($urandom_range(0, 15));
         cin = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: a = 32'hFFFF_FFFF;
            1: a = 32'h7FFF_FFFF;
            2: b = a;
            default: ;
         endcase
         if (in_valid) expect_op(a, b, sel, cin);
         exp_v = in_valid;
      end
      @(negedge clk);
      check_out("rnd.last");
      in_valid = 1'b0;

      // Async reset after capture: clears without a clock edge.
      dir("pre", TA, TB, 4'b0001, 1'b0, 32'hB4B5_4B4A, 1'b0);
      @(negedge clk);
      a = TA; b = TB; sel = 4'b1100; in_valid = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_f = '0; exp_c = 1'b0; exp_v = 1'b0;
      exp_z = 1'b0; exp_n = 1'b0; exp_o = 1'b0;
      check_out("arst");
      // Pending operand presented during reset is discarded.
      @(negedge clk);
      check_out("arst.edge");
      in_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_out("arst.rel");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
